// File: rtl/iz_pkg.sv
// Shared constants and types for the Izhikevich parameter loader and neuron core.
package iz_pkg;

  // Frame start marker
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Fixed-point scale shared with the neuron datapath (real value x64)
  localparam int SCALE = 64;

  // Power-on neuron parameters, already scaled by SCALE
  localparam logic [15:0] DEF_A = 16'h0001;  // 0.02 x64, rounded
  localparam logic [15:0] DEF_B = 16'h000D;  // 0.2  x64
  localparam logic [15:0] DEF_C = 16'hEFC0;  // -65  x64
  localparam logic [15:0] DEF_D = 16'h0200;  // 8    x64

  // Loader FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CSUM    = 2'd2
  } state_t;

endpackage

// File: rtl/iz_byte_timeout.sv
// Inter-byte idle counter: clears on activity, counts idle cycles, flags the
// cycle on which the idle count would reach TIMEOUT_CYC.
module iz_byte_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] LAST  = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] timer;

  // Saturating idle-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (count && (timer != LIMIT)) begin
      timer <= timer + 1'b1;
    end
  end

  // Expiry is reported on the idle cycle whose edge brings the count to TIMEOUT_CYC
  assign expire = count && !clear && (timer == LAST);

endmodule

// File: rtl/iz_param_loader.sv
// Byte-serial loader for Izhikevich neuron parameters: receives a SYNC-framed
// payload of a,b,c,d, checks an XOR checksum and commits all four atomically.
module iz_param_loader #(
  parameter logic [7:0]  SYNC_BYTE      = iz_pkg::SYNC_BYTE,
  parameter int          TIMEOUT_CYC    = 255,
  parameter logic [15:0] DEF_A          = iz_pkg::DEF_A,
  parameter logic [15:0] DEF_B          = iz_pkg::DEF_B,
  parameter logic [15:0] DEF_C          = iz_pkg::DEF_C,
  parameter logic [15:0] DEF_D          = iz_pkg::DEF_D,
  parameter logic        READY_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        abort,
  output logic [15:0] param_a,
  output logic [15:0] param_b,
  output logic [15:0] param_c,
  output logic [15:0] param_d,
  output logic        params_ready,
  output logic        busy,
  output logic        load_done,
  output logic        load_error
);

  import iz_pkg::*;

  state_t      state;
  logic [15:0] shadow [4];
  logic [7:0]  csum;
  logic [2:0]  byte_cnt;
  logic        valid_flag;
  logic        expire;
  logic        tmr_clear;
  logic        tmr_count;

  // Timer only runs inside a frame; any accepted byte or abort restarts it
  assign tmr_count = (state != IDLE);
  assign tmr_clear = data_valid || abort || (state == IDLE);

  iz_byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear),
    .count (tmr_count),
    .expire(expire)
  );

  assign busy = (state != IDLE);

  // Frame FSM, shadow bank and atomic commit of active parameters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      csum         <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      param_a      <= DEF_A;
      param_b      <= DEF_B;
      param_c      <= DEF_C;
      param_d      <= DEF_D;
      params_ready <= READY_AT_RESET;
      valid_flag   <= READY_AT_RESET;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      load_done  <= 1'b0;
      load_error <= 1'b0;
      if ((state != IDLE) && abort) begin
        // Abandon the frame quietly; active params were never touched
        state        <= IDLE;
        params_ready <= valid_flag;
      end else begin
        case (state)
          IDLE: begin
            if (data_valid && (data_in == SYNC_BYTE)) begin
              state        <= PAYLOAD;
              byte_cnt     <= '0;
              csum         <= '0;
              params_ready <= 1'b0;
            end
          end
          PAYLOAD: begin
            if (data_valid) begin
              // Even bytes are high halves, odd bytes low halves (big-endian)
              if (!byte_cnt[0]) shadow[byte_cnt[2:1]][15:8] <= data_in;
              else              shadow[byte_cnt[2:1]][7:0]  <= data_in;
              csum     <= csum ^ data_in;
              byte_cnt <= byte_cnt + 3'd1;
              if (byte_cnt == 3'd7) state <= CSUM;
            end else if (expire) begin
              state        <= IDLE;
              load_error   <= 1'b1;
              params_ready <= valid_flag;
            end
          end
          CSUM: begin
            if (data_valid) begin
              state <= IDLE;
              if (data_in == csum) begin
                param_a      <= shadow[0];
                param_b      <= shadow[1];
                param_c      <= shadow[2];
                param_d      <= shadow[3];
                params_ready <= 1'b1;
                valid_flag   <= 1'b1;
                load_done    <= 1'b1;
              end else begin
                load_error   <= 1'b1;
                params_ready <= valid_flag;
              end
            end else if (expire) begin
              state        <= IDLE;
              load_error   <= 1'b1;
              params_ready <= valid_flag;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
